// File: rtl/spi_sample_scheduler_pkg.sv
// Shared types and default sizing for the SPI microphone sampling scheduler.
package spi_sched_pkg;

  localparam int SCHED_DEPTH = 16;
  localparam int SCHED_DW    = 16;
  localparam int SCHED_PW    = 15;
  localparam int SCHED_TMO   = 255;

  localparam int SCHED_AW = $clog2(SCHED_DEPTH);
  localparam int SCHED_CW = SCHED_AW + 1;
  localparam int SCHED_TW = $clog2(SCHED_TMO + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/spi_sample_scheduler_if.sv
// Capture-engine handshake plus sample read port of the scheduler.
interface spi_sample_scheduler_if
  import spi_sched_pkg::*;
#(
  parameter int DW = SCHED_DW,
  parameter int CW = SCHED_CW
);

  logic          spi_start;
  logic          spi_done;
  logic [DW-1:0] spi_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output spi_start,
    input  spi_done,
    input  spi_data,
    input  rd_en,
    output rd_data,
    output empty,
    output count
  );

  modport slave (
    input  spi_start,
    output spi_done,
    output spi_data,
    output rd_en,
    input  rd_data,
    input  empty,
    input  count
  );

endinterface

// File: rtl/spi_sample_scheduler_fifo.sv
// First-word-fall-through sample FIFO; head reads as zero while empty.
module sample_fifo
  import spi_sched_pkg::*;
#(
  parameter int DEPTH = SCHED_DEPTH,
  parameter int DW    = SCHED_DW
) (
  input  logic                   clk8,
  input  logic                   PRESETn,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && !do_push;
    pop_data = empty ? '0 : mem[rptr];
  end

  always_ff @(posedge clk8 or negedge PRESETn) begin
    if (!PRESETn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk8) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/spi_sample_scheduler.sv
// Periodic SPI sample scheduler: tick generation, capture handshake with timeout,
// sample buffering, sticky error flags and a registered interrupt.
module spi_sample_scheduler
  import spi_sched_pkg::*;
#(
  parameter int DEPTH = SCHED_DEPTH,
  parameter int DW    = SCHED_DW,
  parameter int PW    = SCHED_PW,
  parameter int TMO   = SCHED_TMO
) (
  input  logic                   clk8,
  input  logic                   PRESETn,
  input  logic                   cfg_enable,
  input  logic [PW-1:0]          cfg_period,
  input  logic [$clog2(DEPTH):0] cfg_watermark,
  spi_sample_scheduler_if.master bus,
  output logic                   overflow,
  output logic                   miss,
  input  logic                   err_clr,
  output logic                   irq
);

  localparam int TW = $clog2(TMO + 1);

  sched_state_t  state;
  sched_state_t  state_next;
  logic [PW-1:0] period_cnt;
  logic [PW-1:0] period_next;
  logic [PW-1:0] eff_last;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_next;
  logic          tick;
  logic          timeout;
  logic          push;
  logic          spi_start;
  logic          miss_set;
  logic          fifo_full;
  logic          fifo_drop;

  // Periods below 2 are clamped; a counter already past the compare value runs on and wraps.
  always_comb begin
    eff_last = (cfg_period < PW'(2)) ? PW'(1) : cfg_period - PW'(1);
    tick     = (state != IDLE) && (period_cnt == eff_last);
  end

  always_comb begin
    state_next = state;
    tmo_next   = tmo_cnt;
    push       = 1'b0;
    timeout    = 1'b0;
    spi_start  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable) state_next = ARM;
      end
      ARM: begin
        if (!cfg_enable)  state_next = IDLE;
        else if (tick)    state_next = START;
      end
      START: begin
        spi_start  = 1'b1;
        tmo_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.spi_done) begin
          push       = 1'b1;
          state_next = cfg_enable ? ARM : IDLE;
        end else if (tmo_cnt == TW'(TMO - 1)) begin
          timeout    = 1'b1;
          state_next = cfg_enable ? ARM : IDLE;
        end else begin
          tmo_next = tmo_cnt + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (state == IDLE || state_next == IDLE) period_next = '0;
    else if (tick)                           period_next = '0;
    else                                     period_next = period_cnt + PW'(1);

    // Ticks landing while a transfer is outstanding are reported, never queued.
    miss_set = timeout || (tick && (state == START || state == WAIT));
  end

  assign bus.spi_start = spi_start;

  always_ff @(posedge clk8 or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      period_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_next;
      period_cnt <= period_next;
      tmo_cnt    <= tmo_next;
    end
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk8      (clk8),
    .PRESETn   (PRESETn),
    .push      (push),
    .push_data (bus.spi_data),
    .pop       (bus.rd_en),
    .pop_data  (bus.rd_data),
    .count     (bus.count),
    .full      (fifo_full),
    .empty     (bus.empty),
    .drop      (fifo_drop)
  );

  // Set events win over a simultaneous clear; irq looks at last cycle's flags and count.
  always_ff @(posedge clk8 or negedge PRESETn) begin
    if (!PRESETn) begin
      overflow <= 1'b0;
      miss     <= 1'b0;
      irq      <= 1'b0;
    end else begin
      overflow <= (fifo_drop && fifo_full) || (overflow && !err_clr);
      miss     <= miss_set || (miss && !err_clr);
      irq      <= ((cfg_watermark != '0) && (bus.count >= cfg_watermark)) || overflow || miss;
    end
  end

endmodule

// File: tb/tb_spi_sample_scheduler.sv
// Directed self-checking bench for spi_sample_scheduler with a hand-driven SPI engine.
module tb_spi_sample_scheduler;

  logic        clk8;
  logic        PRESETn;
  logic        cfg_enable;
  logic [14:0] cfg_period;
  logic [4:0]  cfg_watermark;
  logic        err_clr;
  logic        overflow;
  logic        miss;
  logic        irq;

  int checks;
  int errors;
  int n;
  int s;

  spi_sample_scheduler_if bus ();

  spi_sample_scheduler dut (
    .clk8          (clk8),
    .PRESETn       (PRESETn),
    .cfg_enable    (cfg_enable),
    .cfg_period    (cfg_period),
    .cfg_watermark (cfg_watermark),
    .bus           (bus),
    .overflow      (overflow),
    .miss          (miss),
    .err_clr       (err_clr),
    .irq           (irq)
  );

  initial clk8 = 1'b0;
  always #5 clk8 = ~clk8;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until spi_start is seen, giving up at limit.
  task automatic wait_start(input int limit, output int waited);
    waited = 0;
    do begin
      @(negedge clk8);
      waited++;
    end while (bus.spi_start !== 1'b1 && waited < limit);
  endtask

  task automatic count_starts(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk8);
      if (bus.spi_start === 1'b1) seen++;
    end
  endtask

  task automatic apply_transfer(input logic [15:0] data, input int delay);
    repeat (delay) @(negedge clk8);
    bus.spi_done = 1'b1;
    bus.spi_data = data;
    @(negedge clk8);
    bus.spi_done = 1'b0;
    bus.spi_data = '0;
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    @(negedge clk8);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    PRESETn       = 1'b0;
    cfg_enable    = 1'b0;
    cfg_period    = 15'd10;
    cfg_watermark = 5'd0;
    err_clr       = 1'b0;
    bus.spi_done  = 1'b0;
    bus.spi_data  = '0;
    bus.rd_en     = 1'b0;

    repeat (2) @(negedge clk8);
    check_output("rst_start", 32'(bus.spi_start), 32'd0);
    check_output("rst_count", 32'(bus.count), 32'd0);
    check_output("rst_empty", 32'(bus.empty), 32'd1);
    check_output("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check_output("rst_flags", {29'd0, overflow, miss, irq}, 32'd0);
    PRESETn = 1'b1;
    @(negedge clk8);

    // Basic sampling with watermark 4; disable during the fourth transfer.
    $display("[TB] basic sampling / watermark");
    cfg_period    = 15'd10;
    cfg_watermark = 5'd4;
    cfg_enable    = 1'b1;
    wait_start(20, n);
    check_output("first_start", n, 32'd11);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        wait_start(20, n);
        check_output("start_spacing", n, 32'd6);
      end
      if (i == 3) begin
        check_output("irq_below_wm", 32'(irq), 32'd0);
        cfg_enable = 1'b0;
      end
      apply_transfer(16'(16'h1234 + i), 3);
      check_output("count_after_push", 32'(bus.count), 32'(i + 1));
    end
    check_output("irq_lag", 32'(irq), 32'd0);
    @(negedge clk8);
    check_output("irq_at_wm", 32'(irq), 32'd1);
    count_starts(40, s);
    check_output("no_start_after_disable", s, 32'd0);
    check_output("pop_head0", 32'(bus.rd_data), 32'h1234);
    pop_one();
    check_output("count_after_pop", 32'(bus.count), 32'd3);
    @(negedge clk8);
    check_output("irq_after_pop", 32'(irq), 32'd0);
    for (int j = 1; j < 4; j++) begin
      check_output("pop_order", 32'(bus.rd_data), 32'(16'h1234 + j));
      pop_one();
    end
    check_output("drained_empty", 32'(bus.empty), 32'd1);
    check_output("drained_rd_data", 32'(bus.rd_data), 32'd0);

    // Timeout with a period long enough that no tick lands in WAIT.
    $display("[TB] timeout and tick miss");
    cfg_period    = 15'd300;
    cfg_watermark = 5'd0;
    cfg_enable    = 1'b1;
    wait_start(320, n);
    check_output("long_first_start", n, 32'd301);
    repeat (255) @(negedge clk8);
    check_output("miss_before_tmo", 32'(miss), 32'd0);
    @(negedge clk8);
    check_output("miss_at_tmo", 32'(miss), 32'd1);
    @(negedge clk8);
    check_output("irq_from_miss", 32'(irq), 32'd1);
    wait_start(100, n);
    check_output("start_after_tmo", n, 32'd43);
    err_clr    = 1'b1;
    cfg_period = 15'd5;
    @(negedge clk8);
    err_clr = 1'b0;
    repeat (3) @(negedge clk8);
    check_output("miss_cleared", 32'(miss), 32'd0);
    @(negedge clk8);
    check_output("miss_tick_in_wait", 32'(miss), 32'd1);
    apply_transfer(16'h5555, 1);
    check_output("late_done_push", 32'(bus.count), 32'd1);
    wait_start(20, n);
    check_output("no_queued_start", n, 32'd3);

    // Reset asserted while a transfer is outstanding.
    $display("[TB] reset mid-transfer");
    @(negedge clk8);
    cfg_enable = 1'b0;
    PRESETn    = 1'b0;
    #1;
    check_output("mid_rst_start", 32'(bus.spi_start), 32'd0);
    check_output("mid_rst_count", 32'(bus.count), 32'd0);
    check_output("mid_rst_empty", 32'(bus.empty), 32'd1);
    check_output("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
    check_output("mid_rst_flags", {29'd0, overflow, miss, irq}, 32'd0);
    @(negedge clk8);
    PRESETn = 1'b1;
    apply_transfer(16'hBEEF, 1);
    check_output("stray_done_count", 32'(bus.count), 32'd0);
    check_output("stray_done_empty", 32'(bus.empty), 32'd1);
    count_starts(20, s);
    check_output("no_start_after_rst", s, 32'd0);

    // Fill, overflow, clear, then push and pop together while full.
    $display("[TB] overflow and full push/pop");
    cfg_period = 15'd4;
    cfg_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_start(20, n);
      check_output("fill_spacing", n, (i == 0) ? 32'd5 : 32'd2);
      apply_transfer(16'(16'hA000 + i), 1);
    end
    check_output("full_count", 32'(bus.count), 32'd16);
    check_output("full_no_ovf", 32'(overflow), 32'd0);
    check_output("full_irq", 32'(irq), 32'd0);
    wait_start(20, n);
    apply_transfer(16'hA010, 1);
    check_output("ovf_count", 32'(bus.count), 32'd16);
    check_output("ovf_flag", 32'(overflow), 32'd1);
    err_clr   = 1'b1;
    bus.rd_en = 1'b1;
    @(negedge clk8);
    err_clr   = 1'b0;
    bus.rd_en = 1'b0;
    check_output("ovf_cleared", 32'(overflow), 32'd0);
    check_output("count_after_clr_pop", 32'(bus.count), 32'd15);
    check_output("irq_from_ovf", 32'(irq), 32'd1);
    wait_start(20, n);
    check_output("refill_start", n, 32'd1);
    apply_transfer(16'hA011, 1);
    check_output("refull_count", 32'(bus.count), 32'd16);
    wait_start(20, n);
    check_output("last_start", n, 32'd2);
    cfg_enable = 1'b0;
    @(negedge clk8);
    bus.spi_done = 1'b1;
    bus.spi_data = 16'hA012;
    bus.rd_en    = 1'b1;
    @(negedge clk8);
    bus.spi_done = 1'b0;
    bus.spi_data = '0;
    bus.rd_en    = 1'b0;
    check_output("pushpop_count", 32'(bus.count), 32'd16);
    check_output("pushpop_no_ovf", 32'(overflow), 32'd0);
    check_output("pushpop_head", 32'(bus.rd_data), 32'hA002);
    count_starts(30, s);
    check_output("no_start_after_fill", s, 32'd0);
    for (int k = 0; k < 16; k++) begin
      check_output("drain_order", 32'(bus.rd_data),
                   (k < 14) ? 32'(16'hA002 + k) : ((k == 14) ? 32'hA011 : 32'hA012));
      pop_one();
    end
    check_output("drain_empty", 32'(bus.empty), 32'd1);
    check_output("drain_count", 32'(bus.count), 32'd0);

    // A zero period behaves as a period of two.
    $display("[TB] period clamp");
    cfg_period = 15'd0;
    cfg_enable = 1'b1;
    wait_start(20, n);
    check_output("period0_first_start", n, 32'd3);
    cfg_enable = 1'b0;
    apply_transfer(16'h7777, 1);
    check_output("period0_count", 32'(bus.count), 32'd1);
    check_output("period0_data", 32'(bus.rd_data), 32'h7777);
    count_starts(20, s);
    check_output("period0_stopped", s, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
